mips_exec_ctrl: RTL and testbench
=================================

MIPS_EXEC_CTRL -- requirements
Module: mips_exec_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: single rising-edge clock for all registers.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous active-low reset, sampled on rising clock edge.
REQ-003 SHALL have port opcode, input, 6 bits: instruction bits [31:26].
REQ-004 SHALL have port funct, input, 6 bits: instruction bits [5:0], used only when alu_op=10.
REQ-005 SHALL have port operand_a, input, 32 bits: register read data 1, ALU input A.
REQ-006 SHALL have port operand_b, input, 32 bits: register read data 2.
REQ-007 SHALL have port imm, input, 32 bits: sign-extended immediate.
REQ-008 SHALL have port wb, output, 2 bits: {reg_write, mem_to_reg}.
REQ-009 SHALL have port m, output, 3 bits: {branch, mem_read, mem_write}.
REQ-010 SHALL have port ex, output, 4 bits: {reg_dst, alu_op[1:0], alu_src}.
REQ-011 SHALL have port alu_ctl, output, 4 bits: decoded ALU operation.
REQ-012 SHALL have port alu_result, output, 32 bits: ALU result.
REQ-013 SHALL have port zero, output, 1 bit: high when the ALU result is all zeros.

Function
REQ-014 SHALL register every output; all outputs SHALL reflect the inputs sampled at the previous rising edge (latency 1 cycle, no handshake, new operation accepted every cycle).
REQ-015 SHALL decode opcode 000000 (R-type) to wb=10, m=000, ex=1100.
REQ-016 SHALL decode opcode 100011 (lw) to wb=11, m=010, ex=0001.
REQ-017 SHALL decode opcode 101011 (sw) to wb=00, m=001, ex=0001.
REQ-018 SHALL decode opcode 000100 (beq) to wb=00, m=100, ex=0010.
REQ-019 SHALL decode any other opcode to wb=00, m=000, ex=0000.
REQ-020 SHALL derive alu_ctl as follows: alu_op 00 -> 0010 (add); alu_op 01 -> 0110 (sub); alu_op 11 -> 1111.
REQ-021 SHALL derive alu_ctl for alu_op 10 by funct: 100000 -> 0010; 100010 -> 0110; 100100 -> 0000; 100101 -> 0001; 101010 -> 0111; 100111 -> 1100; any other funct -> 1111.
REQ-022 SHALL select ALU input B as imm when alu_src=1, else operand_b.
REQ-023 SHALL compute 0000 A AND B, 0001 A OR B, 0010 A+B, 0110 A-B, 0111 set-less-than, 1100 NOR, 1111 result 0.
REQ-024 SHALL compute add and sub modulo 2^32, with no overflow flag or trap.
REQ-025 SHALL compare set-less-than as signed two's complement, with result 32'h1 when true and 32'h0 otherwise.
REQ-026 SHALL drive zero as (alu_result == 0), computed from the same cycle's result, including for alu_ctl 1111 (zero=1).
REQ-027 SHALL contain no combinational path from any input to any output.

Reset
REQ-028 SHALL clear all output registers to 0 on any rising edge with reset_n=0 (wb=00, m=000, ex=0000, alu_ctl=0000, alu_result=0, zero=0).
REQ-029 SHALL discard the in-flight operation when reset is asserted mid-stream.
REQ-030 SHALL resume normal operation after release, with the first valid output one cycle after the first edge with reset_n=1.
REQ-031 SHALL treat the power-up state before the first reset as undefined; verification SHALL apply reset first.

Verification
REQ-032 SHALL check R-type add: opcode 0, funct 100000, A=5, B=7 -> next cycle alu_result=12, zero=0, alu_ctl=0010, wb=10, m=000, ex=1100.
REQ-033 SHALL check beq on equal operands: opcode 000100, A=B=32'h1234 -> alu_ctl=0110, alu_result=0, zero=1, m=100, ex=0010.
REQ-034 SHALL check lw address: opcode 100011, A=100, imm=4, B=999 -> alu_result=104, wb=11, m=010, ex=0001.
REQ-035 SHALL check signed slt: funct 101010, A=32'hFFFFFFFF, B=1 -> alu_result=1; with A=1, B=32'hFFFFFFFF -> alu_result=0, zero=1.
REQ-036 SHALL check wrap and logic ops: add A=32'hFFFFFFFF, B=1 -> alu_result=0, zero=1; nor A=0, B=0 -> alu_result=32'hFFFFFFFF.
REQ-037 SHALL check reset mid-stream and illegal codes: reset_n=0 during streaming -> all outputs 0 next edge; unknown opcode 111111 -> wb/m/ex all 0, alu_ctl=0010.

Source files
------------

// File: rtl/mips_exec_ctrl.sv
// MIPS execute-stage control: main decode, ALU control and ALU,
// all outputs registered for a fixed one-cycle latency.
module mips_exec_ctrl (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [31:0] imm,
  output logic [1:0]  wb,
  output logic [2:0]  m,
  output logic [3:0]  ex,
  output logic [3:0]  alu_ctl,
  output logic [31:0] alu_result,
  output logic        zero
);

  logic [1:0]  wb_d, wb_q;
  logic [2:0]  m_d, m_q;
  logic [3:0]  ex_d, ex_q;
  logic [3:0]  ctl_d, ctl_q;
  logic [31:0] res_d, res_q;
  logic        zero_d, zero_q;
  logic [1:0]  alu_op;
  logic [31:0] op_b;

  always_comb begin
    wb_d = 2'b00;
    m_d  = 3'b000;
    ex_d = 4'b0000;
    unique case (1'b1)
      (opcode == 6'b000000): begin
        wb_d = 2'b10;
        ex_d = 4'b1100;
      end
      (opcode == 6'b100011): begin
        wb_d = 2'b11;
        m_d  = 3'b010;
        ex_d = 4'b0001;
      end
      (opcode == 6'b101011): begin
        m_d  = 3'b001;
        ex_d = 4'b0001;
      end
      (opcode == 6'b000100): begin
        m_d  = 3'b100;
        ex_d = 4'b0010;
      end
      default: ;
    endcase
  end

  assign alu_op = ex_d[2:1];
  assign op_b   = ex_d[0] ? imm : operand_b;

  always_comb begin
    ctl_d = 4'b1111;
    unique case (alu_op)
      2'b00: ctl_d = 4'b0010;
      2'b01: ctl_d = 4'b0110;
      2'b10: begin
        unique case (funct)
          6'b100000: ctl_d = 4'b0010;
          6'b100010: ctl_d = 4'b0110;
          6'b100100: ctl_d = 4'b0000;
          6'b100101: ctl_d = 4'b0001;
          6'b101010: ctl_d = 4'b0111;
          6'b100111: ctl_d = 4'b1100;
          default:   ctl_d = 4'b1111;
        endcase
      end
      default: ctl_d = 4'b1111;
    endcase
  end

  always_comb begin
    res_d = 32'h0;
    unique case (ctl_d)
      4'b0000: res_d = operand_a & op_b;
      4'b0001: res_d = operand_a | op_b;
      4'b0010: res_d = operand_a + op_b;
      4'b0110: res_d = operand_a - op_b;
      4'b0111: res_d = {31'h0, $signed(operand_a) < $signed(op_b)};
      4'b1100: res_d = ~(operand_a | op_b);
      default: res_d = 32'h0;
    endcase
    zero_d = (res_d == 32'h0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb_q   <= '0;
      m_q    <= '0;
      ex_q   <= '0;
      ctl_q  <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      wb_q   <= wb_d;
      m_q    <= m_d;
      ex_q   <= ex_d;
      ctl_q  <= ctl_d;
      res_q  <= res_d;
      zero_q <= zero_d;
    end
  end

  assign wb         = wb_q;
  assign m          = m_q;
  assign ex         = ex_q;
  assign alu_ctl    = ctl_q;
  assign alu_result = res_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Bench for mips_exec_ctrl: directed cases plus randomized
// instructions against an instruction-level reference model.
module tb_mips_exec_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic [31:0] operand_a, operand_b, imm;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [3:0]  ex, alu_ctl;
  logic [31:0] alu_result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  mips_exec_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .opcode(opcode), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b), .imm(imm),
    .wb(wb), .m(m), .ex(ex), .alu_ctl(alu_ctl),
    .alu_result(alu_result), .zero(zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  // Reference: classify the instruction, then evaluate its operation.
  function automatic exp_t model(input logic [5:0] op,
                                 input logic [5:0] fn,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic [31:0] im);
    exp_t e;
    logic [31:0] x;
    e = '{wb: 2'b00, m: 3'b000, ex: 4'b0000,
          ctl: 4'b0010, res: 32'h0, zero: 1'b0};
    x = b;
    if (op == 6'd0) begin
      e.wb = 2'b10; e.ex = 4'b1100;
      case (fn)
        6'h20: begin e.ctl = 4'b0010; e.res = a + b; end
        6'h22: begin e.ctl = 4'b0110; e.res = a - b; end
        6'h24: begin e.ctl = 4'b0000; e.res = a & b; end
        6'h25: begin e.ctl = 4'b0001; e.res = a | b; end
        6'h2a: begin
          e.ctl = 4'b0111;
          e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        end
        6'h27: begin e.ctl = 4'b1100; e.res = ~(a | b); end
        default: begin e.ctl = 4'b1111; e.res = 32'h0; end
      endcase
    end else if (op == 6'h23) begin
      e.wb = 2'b11; e.m = 3'b010; e.ex = 4'b0001;
      e.res = a + im;
    end else if (op == 6'h2b) begin
      e.m = 3'b001; e.ex = 4'b0001;
      e.res = a + im;
    end else if (op == 6'h04) begin
      e.m = 3'b100; e.ex = 4'b0010;
      e.ctl = 4'b0110; e.res = a - x;
    end else begin
      e.res = a + x;
    end
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("wb", {30'h0, wb}, {30'h0, e.wb});
    chk("m", {29'h0, m}, {29'h0, e.m});
    chk("ex", {28'h0, ex}, {28'h0, e.ex});
    chk("alu_ctl", {28'h0, alu_ctl}, {28'h0, e.ctl});
    chk("alu_result", alu_result, e.res);
    chk("zero", {31'h0, zero}, {31'h0, e.zero});
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im);
    exp_t e;
    opcode = op; funct = fn;
    operand_a = a; operand_b = b; imm = im;
    e = model(op, fn, a, b, im);
    @(posedge clock); #1;
    chk_all(e);
  endtask

  task automatic check_reset_zero();
    exp_t z;
    z = '{wb: 2'b00, m: 3'b000, ex: 4'b0000,
          ctl: 4'b0000, res: 32'h0, zero: 1'b0};
    chk_all(z);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] ops [5];
  logic [5:0] fns [7];

  initial begin
    logic [5:0] rop, rfn;
    ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h3f};
    reset_n = 1'b0;
    opcode = 6'h0; funct = 6'h20;
    operand_a = 32'd5; operand_b = 32'd7; imm = 32'h0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_reset_zero();
    reset_n = 1'b1;

    step(6'h00, 6'h20, 32'd5, 32'd7, 32'h0);
    step(6'h04, 6'h00, 32'h1234, 32'h1234, 32'h0);
    step(6'h23, 6'h00, 32'd100, 32'd999, 32'd4);
    step(6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1, 32'h0);
    step(6'h00, 6'h2a, 32'd1, 32'hFFFFFFFF, 32'h0);
    step(6'h00, 6'h20, 32'hFFFFFFFF, 32'd1, 32'h0);
    step(6'h00, 6'h27, 32'h0, 32'h0, 32'h0);
    step(6'h3f, 6'h22, 32'd3, 32'd4, 32'd9);
    step(6'h2b, 6'h00, 32'hFFFFFFF0, 32'd1, 32'h10);
    step(6'h00, 6'h3f, 32'd8, 32'd9, 32'h0);
    // Literal REQ-032/033 values, independent of the model.
    opcode = 6'h00; funct = 6'h20;
    operand_a = 32'd5; operand_b = 32'd7;
    @(posedge clock); #1;
    chk("add12", alu_result, 32'd12);
    chk("add12_ctl", {28'h0, alu_ctl}, 32'h2);
    opcode = 6'h04; operand_a = 32'h1234; operand_b = 32'h1234;
    @(posedge clock); #1;
    chk("beq_zero", {31'h0, zero}, 32'h1);
    chk("beq_m", {29'h0, m}, 32'h4);

    // Reset mid-stream discards the in-flight operation.
    opcode = 6'h23; operand_a = 32'd1; imm = 32'd1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    check_reset_zero();
    reset_n = 1'b1;
    step(6'h23, 6'h00, 32'd100, 32'd0, 32'd4);

    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom)
                                        : ops[$urandom_range(0, 4)];
      rfn = ($urandom_range(0, 7) == 0) ? 6'($urandom)
                                        : fns[$urandom_range(0, 6)];
      if ($urandom_range(0, 49) == 0) begin
        opcode = rop; funct = rfn;
        reset_n = 1'b0;
        @(posedge clock); #1;
        check_reset_zero();
        reset_n = 1'b1;
      end else begin
        step(rop, rfn, rnd_val(), rnd_val(), rnd_val());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
